// File: rtl/sevens_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : sevens_scan_controller_if
// Description : Signal bundle between the digit encoders, the scan controller
//               and the display pins of an 8-digit seven-segment display.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   segments_in  DIGITS x 8  per-digit cathode patterns, active-low
//                            (bit 7 = decimal point, index 0 = rightmost)
//   digit_mask   DIGITS      1 = digit may light, 0 = digit kept dark
//   brightness   4           global duty level 0..15
//   an           DIGITS      anode enables, active-low
//   ca           8           shared cathode bus, active-low
//   frame_start  1           one-cycle pulse at the start of slot 0
// Modports
//   master : scan controller side (drives the display pins)
//   slave  : encoder / pin side (drives patterns, observes the pins)
// ============================================================================
interface sevens_scan_controller_if #(
  parameter int DIGITS = 8
);
  logic [DIGITS-1:0][7:0] segments_in;
  logic [DIGITS-1:0]      digit_mask;
  logic [3:0]             brightness;
  logic [DIGITS-1:0]      an;
  logic [7:0]             ca;
  logic                   frame_start;

  modport master (
    input  segments_in,
    input  digit_mask,
    input  brightness,
    output an,
    output ca,
    output frame_start
  );

  modport slave (
    output segments_in,
    output digit_mask,
    output brightness,
    input  an,
    input  ca,
    input  frame_start
  );
endinterface
`default_nettype wire

// File: rtl/sevens_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : sevens_scan_controller
// Description : Time-multiplexes per-digit cathode patterns onto one shared
//               cathode bus with per-slot anode enables. Each slot starts
//               with a blanking window (anti-ghosting), followed by a PWM
//               lit window whose length follows the global brightness.
//               Masked digits keep their slot but stay dark.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk     in   system clock
//   resetn  in   asynchronous active-low reset
//   bus     ---  sevens_scan_controller_if.master
//                (segments_in, digit_mask, brightness in; an, ca,
//                 frame_start out, all outputs registered)
// ============================================================================
module sevens_scan_controller #(
  parameter int DIGITS       = 8,
  parameter int SLOT_CYCLES  = 12500,
  parameter int BLANK_CYCLES = 64
) (
  input  wire logic                clk,
  input  wire logic                resetn,
  sevens_scan_controller_if.master bus
);

  localparam int c_CNT_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int c_SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // on_len never exceeds SLOT_CYCLES-BLANK_CYCLES; one spare bit keeps the
  // offset comparison free of wrap-around.
  localparam int c_LEN_W  = c_CNT_W + 1;
  // Active window (< 2^c_CNT_W) times up to 16 needs c_CNT_W+4 bits.
  localparam int c_MUL_W  = c_CNT_W + 5;

  localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(SLOT_CYCLES - 1);
  localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(DIGITS - 1);
  localparam logic [c_CNT_W-1:0]  c_BLANK     = c_CNT_W'(BLANK_CYCLES);
  localparam logic [c_MUL_W-1:0]  c_ACTIVE    = c_MUL_W'(SLOT_CYCLES - BLANK_CYCLES);

  // Scan position
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_SLOT_W-1:0] r_slot;

  // Values captured at the start of each slot
  logic [7:0]          r_seg_l;
  logic                r_en_l;
  logic [c_LEN_W-1:0]  r_on_len;

  // Registered outputs
  logic [DIGITS-1:0]   r_an;
  logic [7:0]          r_ca;
  logic                r_frame_start;

  logic                w_slot_start;
  logic [7:0]          w_seg_new;
  logic                w_en_new;
  logic [c_MUL_W-1:0]  w_prod;
  logic [c_LEN_W-1:0]  w_on_len_new;
  logic [7:0]          w_seg;
  logic                w_en;
  logic [c_LEN_W-1:0]  w_on_len;
  logic                w_past_blank;
  logic [c_LEN_W-1:0]  w_offset;
  logic                w_lit;
  logic [DIGITS-1:0]   w_an_lit;

  assign w_slot_start = (r_cnt == '0);
  assign w_seg_new    = bus.segments_in[r_slot];
  assign w_en_new     = bus.digit_mask[r_slot];
  assign w_prod       = c_ACTIVE * c_MUL_W'({1'b0, bus.brightness} + 5'd1);
  assign w_on_len_new = c_LEN_W'(w_prod >> 4);

  // The slot-start cycle uses the freshly sampled values directly, since the
  // latch and its first use fall in the same cycle.
  assign w_seg    = w_slot_start ? w_seg_new    : r_seg_l;
  assign w_en     = w_slot_start ? w_en_new     : r_en_l;
  assign w_on_len = w_slot_start ? w_on_len_new : r_on_len;

  assign w_past_blank = (r_cnt >= c_BLANK);
  assign w_offset     = {1'b0, r_cnt - c_BLANK};
  assign w_lit        = w_past_blank && (w_offset < w_on_len) && w_en;
  assign w_an_lit     = ~(DIGITS'(1) << r_slot);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt         <= '0;
      r_slot        <= '0;
      r_seg_l       <= '0;
      r_en_l        <= 1'b0;
      r_on_len      <= '0;
      r_an          <= '1;
      r_ca          <= 8'hFF;
      r_frame_start <= 1'b0;
    end else begin
      // Scan position advance
      if (r_cnt == c_CNT_LAST) begin
        r_cnt <= '0;
        if (r_slot == c_SLOT_LAST) begin
          r_slot <= '0;
        end else begin
          r_slot <= r_slot + 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Slot-start capture; held for the rest of the slot
      if (w_slot_start) begin
        r_seg_l  <= w_seg_new;
        r_en_l   <= w_en_new;
        r_on_len <= w_on_len_new;
      end

      // Outputs for the current (slot, cnt); blank and dark look identical
      if (w_lit) begin
        r_an <= w_an_lit;
        r_ca <= w_seg;
      end else begin
        r_an <= '1;
        r_ca <= 8'hFF;
      end

      r_frame_start <= w_slot_start && (r_slot == '0);
    end
  end

  assign bus.an          = r_an;
  assign bus.ca          = r_ca;
  assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_sevens_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevens_scan_controller
// Description : Scoreboard bench for sevens_scan_controller with 8 digits,
//               16-cycle slots and 4 blank cycles. Stimulus pushes the
//               expected pin state of every cycle; a negedge monitor pops
//               and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevens_scan_controller;

  localparam int DIGITS = 8;
  localparam int SLOT   = 16;
  localparam int BLANK  = 4;

  logic clk;
  logic resetn;

  sevens_scan_controller_if #(.DIGITS(DIGITS)) bus ();

  sevens_scan_controller #(
    .DIGITS      (DIGITS),
    .SLOT_CYCLES (SLOT),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [7:0] ca;
    logic       fs;
    int         slot;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Hand-set expectations per slot: lit length, pattern, mask bit
  int         exp_on  [DIGITS];
  logic [7:0] exp_seg [DIGITS];
  logic       exp_msk [DIGITS];

  // Monitor: one expected entry per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (bus.an === e.an && bus.ca === e.ca && bus.frame_start === e.fs) begin
        n_pass++;
      end else begin
        $display("FAIL pins slot=%0d cnt=%0d: got an=%02h ca=%02h fs=%0b, expected an=%02h ca=%02h fs=%0b",
                 e.slot, e.cnt, bus.an, bus.ca, bus.frame_start, e.an, e.ca, e.fs);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] an, input logic [7:0] ca, input logic fs,
                      input int s, input int c);
    exp_t e;
    e.an = an; e.ca = ca; e.fs = fs; e.slot = s; e.cnt = c;
    q.push_back(e);
  endtask

  // Advance one edge; the entry describes the pins after this edge.
  task automatic step(input logic [7:0] an, input logic [7:0] ca, input logic fs,
                      input int s, input int c);
    @(posedge clk);
    #1;
    push(an, ca, fs, s, c);
  endtask

  task automatic run_slot(input int i, input int c0, input int c1);
    logic [7:0] one;
    one = 8'h01;
    for (int c = c0; c <= c1; c++) begin
      logic fs;
      fs = (i == 0 && c == 0);
      if (c < BLANK) begin
        step(8'hFF, 8'hFF, fs, i, c);
      end else if ((c - BLANK) < exp_on[i] && exp_msk[i]) begin
        step(~(one << i), exp_seg[i], fs, i, c);
      end else begin
        step(8'hFF, 8'hFF, fs, i, c);
      end
    end
  endtask

  task automatic run_frame();
    for (int i = 0; i < DIGITS; i++) run_slot(i, 0, SLOT - 1);
  endtask

  task automatic set_on(input int v);
    for (int i = 0; i < DIGITS; i++) exp_on[i] = v;
  endtask

  initial begin
    resetn         = 1'b0;
    bus.brightness = 4'd15;
    bus.digit_mask = 8'hFF;
    for (int i = 0; i < DIGITS; i++) begin
      bus.segments_in[i] = 8'h10 + 8'(i);
      exp_seg[i]         = 8'h10 + 8'(i);
      exp_msk[i]         = 1'b1;
    end

    // Reset held: pins dark, no frame strobe
    for (int k = 0; k < 3; k++) step(8'hFF, 8'hFF, 1'b0, -1, k);
    resetn = 1'b1;

    // Full brightness: 12*16>>4 = 12 lit cycles
    set_on(12);
    run_frame();

    // Mid PWM: 12*8>>4 = 6 lit cycles
    bus.brightness = 4'd7;
    set_on(6);
    run_frame();

    // Minimum: 12*1>>4 = 0, whole frame dark
    bus.brightness = 4'd0;
    set_on(0);
    run_frame();

    // Digit 2 masked, others unaffected
    bus.brightness = 4'd15;
    bus.digit_mask = 8'b1111_1011;
    set_on(12);
    exp_msk[2] = 1'b0;
    run_frame();

    // Mid-slot change at slot 3 cnt 8: slot 3 keeps its captured values,
    // later slots pick up the new brightness at their own start.
    bus.digit_mask = 8'hFF;
    exp_msk[2]     = 1'b1;
    for (int i = 0; i < 3; i++) run_slot(i, 0, SLOT - 1);
    run_slot(3, 0, 8);
    bus.segments_in[3] = 8'hA5;
    bus.brightness     = 4'd7;
    run_slot(3, 9, SLOT - 1);
    for (int i = 4; i < DIGITS; i++) exp_on[i] = 6;
    for (int i = 4; i < DIGITS; i++) run_slot(i, 0, SLOT - 1);

    // Next frame shows the new pattern on digit 3; reset lands at slot 5 cnt 10
    set_on(6);
    exp_seg[3] = 8'hA5;
    for (int i = 0; i < 5; i++) run_slot(i, 0, SLOT - 1);
    run_slot(5, 0, 9);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    push(8'hFF, 8'hFF, 1'b0, 5, 10);
    bus.brightness = 4'd15;
    step(8'hFF, 8'hFF, 1'b0, -1, 0);
    step(8'hFF, 8'hFF, 1'b0, -1, 1);
    resetn = 1'b1;

    // Scan restarts at slot 0 with the strobe on the first cycle
    set_on(12);
    run_frame();
    run_slot(0, 0, 0);

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
